// File: rtl/snd_defs_pkg.sv
// Shared constants for the 68K->Z80 sound command path: Z80 IO port numbers,
// the RST 38h vector byte, and the default periodic-IRQ divider.
package snd_defs_pkg;

  localparam logic [7:0] SND_PORT_CLR    = 8'h04;
  localparam logic [7:0] SND_PORT_RD     = 8'h06;
  localparam logic [7:0] RST38_VEC       = 8'hFF;
  localparam int         IRQ_DIV_DEFAULT = 512;

  // The command byte always carries a set LSB so the Z80 can tell "new command" from idle 00h.
  function automatic logic [7:0] latch_code(input logic [6:0] cmd);
    return {cmd, 1'b1};
  endfunction

endpackage

// File: rtl/snd_irq_timer.sv
// Periodic Z80 IRQ source: divides z80_cen by IRQ_DIV, pulls INT_n low on wrap,
// and releases it on the first rising edge of the interrupt acknowledge.
module snd_irq_timer #(
  parameter int IRQ_DIV = 512,
  parameter int CNT_W   = 10
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic z80_cen,
  input  logic ack_edge,
  output logic z80_int_n
);

  logic [CNT_W-1:0] count_reg;
  logic             wrap;

  assign wrap = z80_cen && (count_reg == CNT_W'(IRQ_DIV - 1));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
      z80_int_n <= 1'b1;
    end else begin
      if (z80_cen)
        count_reg <= wrap ? '0 : count_reg + 1'b1;
      // A wrap coinciding with an acknowledge keeps INT asserted: the new request must not be lost.
      if (wrap)
        z80_int_n <= 1'b0;
      else if (ack_edge)
        z80_int_n <= 1'b1;
    end
  end

endmodule

// File: rtl/sound_latch_bridge.sv
// 68K->Z80 sound command latch, Z80 read-data mux and interrupt generation.
// Optional write-triggered NMI pulse is enabled by defining SND_NMI_ON_WRITE_EN.
module sound_latch_bridge
  import snd_defs_pkg::*;
#(
  parameter int IRQ_DIV   = IRQ_DIV_DEFAULT,
  parameter int CNT_W     = 10,
  parameter int NMI_WIDTH = 4
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        z80_cen,
  input  logic [15:0] m68k_din,
  input  logic        m68k_rw,
  input  logic        m68k_lds_n,
  input  logic        sound_latch_cs,
  input  logic        z80_latch_clr_cs,
  input  logic        z80_latch_r_cs,
  input  logic        z80_rd_n,
  input  logic        M1_n,
  input  logic        IORQ_n,
  output logic [7:0]  z80_dout,
  output logic        z80_dout_en,
  output logic        z80_int_n,
  output logic        z80_nmi_n,
  output logic        latch_pending
);

  logic       wr, clr, rd, ack;
  logic       wr_d_reg, clr_d_reg, ack_d_reg;
  logic       wr_edge, clr_edge, ack_edge;
  logic [7:0] latch_reg;

  // Only the low seven data bits form the command.
  logic unused_din;
  assign unused_din = &{1'b0, m68k_din[15:7]};

  assign wr  = sound_latch_cs & ~m68k_rw & ~m68k_lds_n;
  assign clr = z80_latch_clr_cs & ~z80_rd_n;
  assign rd  = z80_latch_r_cs & ~z80_rd_n;
  assign ack = ~M1_n & ~IORQ_n;

  assign wr_edge  = wr  & ~wr_d_reg;
  assign clr_edge = clr & ~clr_d_reg;
  assign ack_edge = ack & ~ack_d_reg;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_d_reg      <= 1'b0;
      clr_d_reg     <= 1'b0;
      ack_d_reg     <= 1'b0;
      latch_reg     <= 8'h00;
      latch_pending <= 1'b0;
    end else begin
      wr_d_reg  <= wr;
      clr_d_reg <= clr;
      ack_d_reg <= ack;
      // Write checked first so a simultaneous clear cannot swallow a fresh command.
      if (wr_edge) begin
        latch_reg     <= latch_code(m68k_din[6:0]);
        latch_pending <= 1'b1;
      end else if (clr_edge) begin
        latch_reg     <= 8'h00;
        latch_pending <= 1'b0;
      end
    end
  end

  always_comb begin
    z80_dout    = RST38_VEC;
    z80_dout_en = 1'b0;
    if (ack) begin
      z80_dout    = RST38_VEC;
      z80_dout_en = 1'b1;
    end else if (rd) begin
      z80_dout    = latch_reg;
      z80_dout_en = 1'b1;
    end
  end

  snd_irq_timer #(
    .IRQ_DIV (IRQ_DIV),
    .CNT_W   (CNT_W)
  ) u_irq_timer (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .z80_cen   (z80_cen),
    .ack_edge  (ack_edge),
    .z80_int_n (z80_int_n)
  );

`ifdef SND_NMI_ON_WRITE_EN
  localparam int NMI_CNT_W = $clog2(NMI_WIDTH + 1);

  logic [NMI_CNT_W-1:0] nmi_cnt_reg;

  // Remaining cen pulses of NMI low time; a new write reloads it.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)
      nmi_cnt_reg <= '0;
    else if (wr_edge)
      nmi_cnt_reg <= NMI_CNT_W'(NMI_WIDTH);
    else if (z80_cen && (nmi_cnt_reg != '0))
      nmi_cnt_reg <= nmi_cnt_reg - 1'b1;
  end

  assign z80_nmi_n = (nmi_cnt_reg == '0);
`else
  localparam int unused_nmi_width = NMI_WIDTH;
  assign z80_nmi_n = 1'b1;
`endif

endmodule

// File: tb/tb_sound_latch_bridge.sv
// Scoreboard bench for sound_latch_bridge: expected latch/pending values are queued
// when 68K/Z80 stimulus is applied and compared when the Z80 reads port 06h.
module tb_sound_latch_bridge;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        z80_cen = 1'b0;
  logic [15:0] m68k_din;
  logic        m68k_rw, m68k_lds_n, sound_latch_cs;
  logic        z80_latch_clr_cs, z80_latch_r_cs, z80_rd_n, M1_n, IORQ_n;
  logic [7:0]  z80_dout;
  logic        z80_dout_en, z80_int_n, z80_nmi_n, latch_pending;

  int          errors = 0;
  int          checks = 0;
  int          cen_seen;
  int          cen_phase = 0;
  int          c0;
  logic [8:0]  exp_q[$];
  logic [7:0]  model_latch;
  logic        model_pend;

  always #5 clk_sys = ~clk_sys;

  sound_latch_bridge dut (
    .clk_sys          (clk_sys),
    .reset_n          (reset_n),
    .z80_cen          (z80_cen),
    .m68k_din         (m68k_din),
    .m68k_rw          (m68k_rw),
    .m68k_lds_n       (m68k_lds_n),
    .sound_latch_cs   (sound_latch_cs),
    .z80_latch_clr_cs (z80_latch_clr_cs),
    .z80_latch_r_cs   (z80_latch_r_cs),
    .z80_rd_n         (z80_rd_n),
    .M1_n             (M1_n),
    .IORQ_n           (IORQ_n),
    .z80_dout         (z80_dout),
    .z80_dout_en      (z80_dout_en),
    .z80_int_n        (z80_int_n),
    .z80_nmi_n        (z80_nmi_n),
    .latch_pending    (latch_pending)
  );

  // z80_cen: one clk high every 4th clk, changed just after the rising edge.
  initial begin
    forever begin
      @(posedge clk_sys);
      #1;
      cen_phase++;
      z80_cen = ((cen_phase % 4) == 0);
    end
  end

  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)
      cen_seen <= 0;
    else if (z80_cen)
      cen_seen <= cen_seen + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #2;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    model_latch = 8'h00;
    model_pend  = 1'b0;
  endtask

  task automatic m68k_write(input logic [15:0] d);
    sound_latch_cs = 1'b1; m68k_rw = 1'b0; m68k_lds_n = 1'b0; m68k_din = d;
    step();
    sound_latch_cs = 1'b0; m68k_rw = 1'b1; m68k_lds_n = 1'b1;
    model_latch = {d[6:0], 1'b1};
    model_pend  = 1'b1;
  endtask

  task automatic z80_clear();
    z80_latch_clr_cs = 1'b1; z80_rd_n = 1'b0;
    step();
    z80_latch_clr_cs = 1'b0; z80_rd_n = 1'b1;
    model_latch = 8'h00;
    model_pend  = 1'b0;
  endtask

  task automatic z80_read(input string tag);
    logic [8:0] e;
    exp_q.push_back({model_pend, model_latch});
    z80_latch_r_cs = 1'b1; z80_rd_n = 1'b0;
    @(negedge clk_sys);
    e = exp_q.pop_front();
    check({tag, "_dout"}, {24'd0, z80_dout}, {24'd0, e[7:0]});
    check({tag, "_en"}, {31'd0, z80_dout_en}, 32'd1);
    check({tag, "_pend"}, {31'd0, latch_pending}, {31'd0, e[8]});
    $display("read %s: dout=%02h pending=%0d", tag, z80_dout, latch_pending);
    z80_latch_r_cs = 1'b0; z80_rd_n = 1'b1;
    step();
  endtask

  task automatic wait_int_low(input string tag, input int exp_cen);
    int i;
    for (i = 0; i < 4000; i++) begin
      @(negedge clk_sys);
      if (!z80_int_n) break;
    end
    check({tag, "_low"}, {31'd0, z80_int_n}, 32'd0);
    check({tag, "_cen"}, cen_seen, exp_cen);
    $display("irq %s: int_n fell after %0d cen pulses", tag, cen_seen);
  endtask

  initial begin
    reset_n = 1'b0; m68k_din = 16'h0; m68k_rw = 1'b1; m68k_lds_n = 1'b1;
    sound_latch_cs = 1'b0; z80_latch_clr_cs = 1'b0; z80_latch_r_cs = 1'b0;
    z80_rd_n = 1'b1; M1_n = 1'b1; IORQ_n = 1'b1;
    do_reset();

    @(negedge clk_sys);
    check("rst_int_n", {31'd0, z80_int_n}, 32'd1);
    check("rst_nmi_n", {31'd0, z80_nmi_n}, 32'd1);
    check("rst_pend", {31'd0, latch_pending}, 32'd0);
    check("idle_en", {31'd0, z80_dout_en}, 32'd0);
    check("idle_dout", {24'd0, z80_dout}, 32'hFF);
    step();
    z80_read("rst");

    // Basic write, non-destructive read, clear.
    m68k_write(16'h0035);
    z80_read("w35");
    z80_read("w35_again");
    z80_clear();
    z80_read("after_clr");

    // Strobe held 8 clks; data changes mid-strobe must be ignored.
    sound_latch_cs = 1'b1; m68k_rw = 1'b0; m68k_lds_n = 1'b0; m68k_din = 16'h007F;
    repeat (3) step();
    m68k_din = 16'h0000;
    repeat (5) step();
    sound_latch_cs = 1'b0; m68k_rw = 1'b1; m68k_lds_n = 1'b1;
    model_latch = 8'hFF; model_pend = 1'b1;
    z80_read("hold");

    // Write edge and clear edge in the same clk: write wins.
    z80_clear();
    sound_latch_cs = 1'b1; m68k_rw = 1'b0; m68k_lds_n = 1'b0; m68k_din = 16'h0001;
    z80_latch_clr_cs = 1'b1; z80_rd_n = 1'b0;
    step();
    sound_latch_cs = 1'b0; m68k_rw = 1'b1; m68k_lds_n = 1'b1;
    z80_latch_clr_cs = 1'b0; z80_rd_n = 1'b1;
    model_latch = 8'h03; model_pend = 1'b1;
    z80_read("wr_vs_clr");

    // IRQ ack overrides a port read.
    z80_latch_r_cs = 1'b1; z80_rd_n = 1'b0; M1_n = 1'b0; IORQ_n = 1'b0;
    @(negedge clk_sys);
    check("ack_prio_dout", {24'd0, z80_dout}, 32'hFF);
    check("ack_prio_en", {31'd0, z80_dout_en}, 32'd1);
    z80_latch_r_cs = 1'b0; z80_rd_n = 1'b1; M1_n = 1'b1; IORQ_n = 1'b1;
    step();

    // Periodic IRQ timing.
    do_reset();
    wait_int_low("irq1", 512);
    for (int i = 0; i < 6000 && cen_seen < 1536; i++) @(negedge clk_sys);
    check("int_held", {31'd0, z80_int_n}, 32'd0);
    step();
    M1_n = 1'b0; IORQ_n = 1'b0;
    @(negedge clk_sys);
    check("ack_dout", {24'd0, z80_dout}, 32'hFF);
    check("ack_en", {31'd0, z80_dout_en}, 32'd1);
    check("ack_int_same", {31'd0, z80_int_n}, 32'd0);
    step();
    check("ack_int_rel", {31'd0, z80_int_n}, 32'd1);
    M1_n = 1'b1; IORQ_n = 1'b1;
    step();

    // Ack edge coinciding with a wrap: INT must stay low.
    for (int i = 0; i < 3000 && !(cen_seen == 2047 && z80_cen); i++) step();
    M1_n = 1'b0; IORQ_n = 1'b0;
    step();
    check("wrap_vs_ack", {31'd0, z80_int_n}, 32'd0);
    M1_n = 1'b1; IORQ_n = 1'b1;
    step();

    // Asynchronous reset during a write strobe with INT low.
    sound_latch_cs = 1'b1; m68k_rw = 1'b0; m68k_lds_n = 1'b0; m68k_din = 16'h0022;
    #1 reset_n = 1'b0;
    #1;
    check("arst_pend", {31'd0, latch_pending}, 32'd0);
    check("arst_int_n", {31'd0, z80_int_n}, 32'd1);
    check("arst_nmi_n", {31'd0, z80_nmi_n}, 32'd1);
    check("arst_en", {31'd0, z80_dout_en}, 32'd0);
    sound_latch_cs = 1'b0; m68k_rw = 1'b1; m68k_lds_n = 1'b1;
    repeat (2) step();
    reset_n = 1'b1;
    model_latch = 8'h00; model_pend = 1'b0;
    z80_read("after_arst");
    wait_int_low("irq_restart", 512);

`ifdef SND_NMI_ON_WRITE_EN
    step();
    m68k_write(16'h0001);
    check("nmi_low", {31'd0, z80_nmi_n}, 32'd0);
    c0 = cen_seen;
    for (int i = 0; i < 200 && !z80_nmi_n; i++) @(negedge clk_sys);
    check("nmi_width", cen_seen - c0, 4);
    step();
    m68k_write(16'h0002);
    c0 = cen_seen;
    for (int i = 0; i < 200 && !((cen_seen - c0) == 2 && !z80_cen); i++) step();
    m68k_write(16'h0003);
    for (int i = 0; i < 200 && !z80_nmi_n; i++) @(negedge clk_sys);
    check("nmi_restart", cen_seen - c0, 6);
`else
    m68k_write(16'h0001);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_sys);
      check("nmi_tied", {31'd0, z80_nmi_n}, 32'd1);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
